// File: rtl/gpio_input_conditioner.sv
// Pad-side input conditioning for gpio_controller: 2-flop sync, per-bit debounce,
// edge detection on input-direction bits, sticky pending flags and an OR-ed irq.
module gpio_ic_lane #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    input  logic qual,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clr,
    output logic i,
    output logic pend,
    output logic pend_nxt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DB_CYCLES - 1);

    logic                 s1, s2, i_d, ev;
    logic [CNT_WIDTH-1:0] cnt;

    // Edges are seen one cycle after i moves, so pend/irq lag i by one cycle.
    assign ev       = qual & ((i & ~i_d & rise_en) | (~i & i_d & fall_en));
    assign pend_nxt = (pend & ~clr) | ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            i    <= 1'b0;
            i_d  <= 1'b0;
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            i_d  <= i;
            pend <= pend_nxt;
            if (s2 == i) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                i   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module gpio_input_conditioner #(
    parameter int   WIDTH     = 8,
    parameter int   DB_CYCLES = 16,
    parameter int   CNT_WIDTH = 5,
    parameter logic DIR_IN    = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] dir,
    output logic [WIDTH-1:0] i,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] pend_clr,
    output logic [WIDTH-1:0] pend,
    output logic             irq
);
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] pend_nxt;

    assign qual = ~(dir ^ {WIDTH{DIR_IN}});

    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        gpio_ic_lane #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .pin      (pin_i[b]),
            .qual     (qual[b]),
            .rise_en  (rise_en[b]),
            .fall_en  (fall_en[b]),
            .clr      (pend_clr[b]),
            .i        (i[b]),
            .pend     (pend[b]),
            .pend_nxt (pend_nxt[b])
        );
    end

    // irq is built from next-state pend so it changes on the same edge as pend.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) irq <= 1'b0;
        else       irq <= |pend_nxt;
    end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Randomised + directed bench for gpio_input_conditioner against a behavioural
// model of sync delay, debounce run length, edge qualification and sticky pend.
module tb_gpio_input_conditioner;
    localparam int   W      = 8;
    localparam int   DB     = 4;
    localparam int   CW     = 3;
    localparam logic DIR_IN = 1'b0;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] pin_i = '0, dir = '0, rise_en = '0, fall_en = '0, pend_clr = '0;
    logic [W-1:0] i, pend;
    logic         irq;

    gpio_input_conditioner #(
        .WIDTH(W), .DB_CYCLES(DB), .CNT_WIDTH(CW), .DIR_IN(DIR_IN)
    ) dut (
        .clk(clk), .rstn(rstn), .pin_i(pin_i), .dir(dir), .i(i),
        .rise_en(rise_en), .fall_en(fall_en), .pend_clr(pend_clr),
        .pend(pend), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: pad samples reach the debouncer two edges later; a bit of
    // i flips once DB consecutive samples disagree with it.
    logic [W-1:0] pipe_q[$];
    int           run[W];
    logic [W-1:0] m_i = '0, m_id = '0, m_pend = '0;
    logic         m_irq = 1'b0;

    initial begin
        logic [W-1:0] s2v, ev, np;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                pipe_q.delete();
                pipe_q.push_back('0);
                pipe_q.push_back('0);
                for (int b = 0; b < W; b++) run[b] = 0;
                m_i = '0; m_id = '0; m_pend = '0; m_irq = 1'b0;
            end else begin
                s2v = pipe_q.pop_front();
                pipe_q.push_back(pin_i);
                ev = ((m_i & ~m_id & rise_en) | (~m_i & m_id & fall_en))
                     & ~(dir ^ {W{DIR_IN}});
                np     = (m_pend & ~pend_clr) | ev;
                m_irq  = |np;
                m_pend = np;
                m_id   = m_i;
                for (int b = 0; b < W; b++) begin
                    if (s2v[b] != m_i[b]) begin
                        run[b]++;
                        if (run[b] >= DB) begin
                            m_i[b] = s2v[b];
                            run[b] = 0;
                        end
                    end else begin
                        run[b] = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("model_i", 32'(i), 32'(m_i));
                chk("model_pend", 32'(pend), 32'(m_pend));
                chk("model_irq", 32'(irq), 32'(m_irq));
            end
        end
    end

    initial begin
        wait_n(3);
        chk("reset_i", 32'(i), 32'h0);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rstn = 1'b1;
        wait_n(4);

        // Step on bit 0: i follows exactly 2+DB edges after the pad change.
        pin_i = 8'h01;
        wait_n(5);
        chk("step_early", 32'(i), 32'h00);
        wait_n(1);
        chk("step_latency", 32'(i), 32'h01);

        // 3-cycle glitch is filtered; 4-cycle pulse passes for 4 cycles.
        pin_i[1] = 1'b1; wait_n(3); pin_i[1] = 1'b0;
        wait_n(10);
        chk("glitch_i", 32'(i), 32'h01);
        chk("glitch_pend", 32'(pend), 32'h00);
        pin_i[1] = 1'b1; wait_n(4); pin_i[1] = 1'b0;
        wait_n(1); chk("pulse_pre", 32'(i[1]), 32'h0);
        wait_n(1); chk("pulse_rise", 32'(i[1]), 32'h1);
        wait_n(3); chk("pulse_hold", 32'(i[1]), 32'h1);
        wait_n(1); chk("pulse_fall", 32'(i[1]), 32'h0);

        // Qualified rise on bit 2 sets pend/irq one cycle after i rises.
        rise_en = 8'h04;
        pin_i[2] = 1'b1;
        wait_n(6);
        chk("rise_i", 32'(i), 32'h05);
        chk("rise_pend_pre", 32'(pend), 32'h00);
        wait_n(1);
        chk("rise_pend", 32'(pend), 32'h04);
        chk("rise_irq", 32'(irq), 32'h1);
        pend_clr = 8'h04; wait_n(1); pend_clr = 8'h00;
        chk("clr_pend", 32'(pend), 32'h00);
        chk("clr_irq", 32'(irq), 32'h0);
        pin_i[2] = 1'b0; wait_n(8);
        dir[2] = 1'b1; pin_i[2] = 1'b1; wait_n(10);
        chk("out_readback", 32'(i[2]), 32'h1);
        chk("out_no_pend", 32'(pend), 32'h00);
        dir[2] = 1'b0;

        // Clear coincident with a new fall event must not lose the event.
        fall_en = 8'h04;
        pin_i[2] = 1'b0;
        wait_n(6);
        pend_clr = 8'h04;
        wait_n(1);
        chk("setclr_pend", 32'(pend), 32'h04);
        chk("setclr_irq", 32'(irq), 32'h1);
        wait_n(1);
        pend_clr = 8'h00;
        chk("clr2_pend", 32'(pend), 32'h00);
        chk("clr2_irq", 32'(irq), 32'h0);

        // Async reset mid-count with pend=05, then power-up rise after release.
        fall_en = 8'h00; rise_en = 8'hff;
        pin_i = 8'h00; wait_n(8);
        pin_i = 8'h05; wait_n(7);
        chk("pre_rst_pend", 32'(pend), 32'h05);
        pin_i = 8'h07; wait_n(2);
        #2 rstn = 1'b0;
        #1;
        chk("async_i", 32'(i), 32'h00);
        chk("async_pend", 32'(pend), 32'h00);
        chk("async_irq", 32'(irq), 32'h0);
        wait_n(3);
        rstn = 1'b1;
        wait_n(6);
        chk("pwrup_i", 32'(i), 32'h07);
        chk("pwrup_pend_pre", 32'(pend), 32'h00);
        wait_n(1);
        chk("pwrup_pend", 32'(pend), 32'h07);
        wait_n(5);
        chk("pwrup_single", 32'(pend), 32'h07);

        // Random pad noise with occasional reconfiguration and one reset.
        for (int c = 0; c < 20000; c++) begin
            int noisy;
            noisy = ((c / 500) % 2 == 0);
            for (int b = 0; b < W; b++)
                if ($urandom_range(noisy ? 2 : 15, 0) == 0) pin_i[b] = ~pin_i[b];
            if ($urandom_range(63, 0) == 0) dir     = W'($urandom);
            if ($urandom_range(63, 0) == 0) rise_en = W'($urandom);
            if ($urandom_range(63, 0) == 0) fall_en = W'($urandom);
            pend_clr = W'($urandom & $urandom & $urandom);
            if (c == 10000) begin
                #3 rstn = 1'b0;
                wait_n(2);
                rstn = 1'b1;
            end
            wait_n(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
